// File: rtl/uart_rx_frame_ctrl_if.sv
// Frame delivery bus between the UART RX frame controller and its consumer.
// One-deep buffer contents plus the valid/ready handshake.
interface uart_rx_frame_ctrl_if;
    logic [7:0] frame_addr;
    logic [7:0] frame_cmd;
    logic       frame_valid;
    logic       frame_ready;

    modport master (
        output frame_addr,
        output frame_cmd,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_addr,
        input  frame_cmd,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: pairs bytes into (addr, cmd) frames,
// buffers one frame, recovers from line errors and counts faults.
module uart_rx_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 640
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_done,
    input  logic                        rx_err,
    input  logic                        rx_busy,
    output logic                        rx_en,
    uart_rx_frame_ctrl_if.master        frm,
    output logic                        timeout,
    output logic                        overrun,
    output logic [7:0]                  err_cnt
);

    localparam int TW = 10;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        DISABLED,
        RECOVER,
        WAIT_ADDR,
        WAIT_CMD
    } state_t;

    state_t        state_q, state_d;
    logic          rec_q, rec_d;
    logic [7:0]    addr_q, addr_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          rx_en_q, rx_en_d;
    logic [7:0]    faddr_q, faddr_d;
    logic [7:0]    fcmd_q, fcmd_d;
    logic          fvalid_q, fvalid_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    err_q, err_d;

    logic          line_err;
    logic          tmo_hit;
    logic          frm_done;
    logic          take;
    logic          accept;
    logic          drop;

    // Receiver busy is informational only; nothing here depends on it.
    logic unused_busy;
    assign unused_busy = rx_busy;

    always_comb begin
        state_d  = state_q;
        rec_d    = rec_q;
        addr_d   = addr_q;
        tmo_d    = tmo_q;
        line_err = 1'b0;
        tmo_hit  = 1'b0;
        frm_done = 1'b0;
        if (!enable) begin
            state_d = DISABLED;
            rec_d   = 1'b0;
            addr_d  = '0;
            tmo_d   = '0;
        end else begin
            unique case (state_q)
                DISABLED: begin
                    state_d = WAIT_ADDR;
                end
                RECOVER: begin
                    if (rec_q) begin
                        state_d = WAIT_ADDR;
                        rec_d   = 1'b0;
                    end else begin
                        rec_d = 1'b1;
                    end
                end
                WAIT_ADDR: begin
                    if (rx_err) begin
                        state_d  = RECOVER;
                        rec_d    = 1'b0;
                        addr_d   = '0;
                        line_err = 1'b1;
                    end else if (rx_done) begin
                        state_d = WAIT_CMD;
                        addr_d  = rx_data;
                        tmo_d   = '0;
                    end
                end
                WAIT_CMD: begin
                    if (rx_err) begin
                        state_d  = RECOVER;
                        rec_d    = 1'b0;
                        addr_d   = '0;
                        line_err = 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = WAIT_ADDR;
                        addr_d  = '0;
                        tmo_d   = '0;
                        tmo_hit = 1'b1;
                    end else if (rx_done) begin
                        state_d  = WAIT_ADDR;
                        frm_done = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_d = DISABLED;
                end
            endcase
        end
    end

    // A full buffer can take a new frame only if it drains the same cycle.
    assign take   = fvalid_q && frm.frame_ready;
    assign accept = frm_done && (!fvalid_q || take);
    assign drop   = frm_done && !accept;

    always_comb begin
        faddr_d   = faddr_q;
        fcmd_d    = fcmd_q;
        fvalid_d  = fvalid_q;
        timeout_d = tmo_hit;
        overrun_d = drop;
        err_d     = err_q;
        rx_en_d   = (state_d == WAIT_ADDR) || (state_d == WAIT_CMD);
        if (accept) begin
            faddr_d  = addr_q;
            fcmd_d   = rx_data;
            fvalid_d = 1'b1;
        end else if (take) begin
            fvalid_d = 1'b0;
        end
        if ((line_err || tmo_hit || drop) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DISABLED;
            rec_q     <= 1'b0;
            addr_q    <= '0;
            tmo_q     <= '0;
            rx_en_q   <= 1'b0;
            faddr_q   <= '0;
            fcmd_q    <= '0;
            fvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            rec_q     <= rec_d;
            addr_q    <= addr_d;
            tmo_q     <= tmo_d;
            rx_en_q   <= rx_en_d;
            faddr_q   <= faddr_d;
            fcmd_q    <= fcmd_d;
            fvalid_q  <= fvalid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
        end
    end

    assign rx_en           = rx_en_q;
    assign frm.frame_addr  = faddr_q;
    assign frm.frame_cmd   = fcmd_q;
    assign frm.frame_valid = fvalid_q;
    assign timeout         = timeout_q;
    assign overrun         = overrun_q;
    assign err_cnt         = err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomized scoreboard bench for uart_rx_frame_ctrl.
// Expected frames are queued by a behavioural model and popped on delivery.
module tb_uart_rx_frame_ctrl;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rx_err = 1'b0;
    logic       rx_busy = 1'b0;
    logic       rx_en;
    logic       timeout;
    logic       overrun;
    logic [7:0] err_cnt;

    uart_rx_frame_ctrl_if fif ();

    uart_rx_frame_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rx_err  (rx_err),
        .rx_busy (rx_busy),
        .rx_en   (rx_en),
        .frm     (fif.master),
        .timeout (timeout),
        .overrun (overrun),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: listening / off / recovering, plus a pending
    // address with its age, a one-deep buffer and a fault tally.
    int          m_mode;
    bit          m_have;
    logic [7:0]  m_addr;
    int          m_since;
    int          m_rec;
    bit          m_bv;
    int          m_errs;
    bit          m_to;
    bit          m_ov;
    logic [15:0] sb[$];

    task automatic model_reset();
        m_mode = 0; m_have = 0; m_addr = 0; m_since = 0; m_rec = 0;
        m_bv = 0; m_errs = 0; m_to = 0; m_ov = 0;
        sb.delete();
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            bit deliver;
            m_to = 0;
            m_ov = 0;
            deliver = m_bv && fif.frame_ready;
            if (deliver) m_bv = 0;
            if (!enable) begin
                m_mode = 0;
                m_have = 0;
            end else if (m_mode == 0) begin
                m_mode = 2;
            end else if (m_mode == 1) begin
                m_rec--;
                if (m_rec == 0) m_mode = 2;
            end else if (rx_err) begin
                m_mode = 1; m_rec = 2; m_have = 0; m_errs++;
            end else if (m_have && m_since == T - 1) begin
                m_have = 0; m_to = 1; m_errs++;
            end else if (rx_done && !m_have) begin
                m_addr = rx_data; m_have = 1; m_since = 0;
            end else if (rx_done) begin
                m_have = 0;
                if (!m_bv) begin
                    m_bv = 1;
                    sb.push_back({m_addr, rx_data});
                end else begin
                    m_ov = 1; m_errs++;
                end
            end else if (m_have) begin
                m_since++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("rx_en", rx_en, m_mode == 2);
            check("timeout", timeout, m_to);
            check("overrun", overrun, m_ov);
            check("err_cnt", err_cnt, (m_errs > 255) ? 255 : m_errs);
            check("frame_valid", fif.frame_valid, m_bv);
            if (fif.frame_valid) begin
                if (sb.size() == 0) begin
                    check("frame_unexpected", 1, 0);
                end else begin
                    check("frame_addr", fif.frame_addr, sb[0][15:8]);
                    check("frame_cmd", fif.frame_cmd, sb[0][7:0]);
                    if (fif.frame_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rx_en", rx_en, 0);
        check("rst_valid", fif.frame_valid, 0);
        check("rst_addr", fif.frame_addr, 0);
        check("rst_cmd", fif.frame_cmd, 0);
        check("rst_err", err_cnt, 0);
        check("rst_to_ov", {timeout, overrun}, 0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        fif.frame_ready = 1'b0;
        do_reset();

        // basic frame
        enable = 1'b1;
        fif.frame_ready = 1'b1;
        idle(2);
        send(8'h5A);
        send(8'hC3);
        check("basic_valid", fif.frame_valid, 1);
        check("basic_frame", {fif.frame_addr, fif.frame_cmd}, 16'h5AC3);
        check("basic_err", err_cnt, 0);
        idle(3);

        // backpressure
        fif.frame_ready = 1'b0;
        send(8'h01); send(8'h02);
        send(8'h03); send(8'h04);
        check("bp_overrun", overrun, 1);
        check("bp_err", err_cnt, 1);
        check("bp_frame", {fif.frame_addr, fif.frame_cmd}, 16'h0102);
        tick();
        fif.frame_ready = 1'b1;
        idle(3);

        // line error during command wait
        send(8'h11);
        rx_err = 1'b1;
        tick();
        check("le_en0", rx_en, 0);
        check("le_err", err_cnt, 2);
        tick();
        check("le_en1", rx_en, 0);
        rx_err = 1'b0;
        tick();
        check("le_en2", rx_en, 1);
        send(8'h22); send(8'h33);
        check("le_frame", {fif.frame_addr, fif.frame_cmd}, 16'h2233);
        idle(2);

        // timeout
        send(8'h7E);
        idle(T - 1);
        check("to_early", timeout, 0);
        tick();
        check("to_pulse", timeout, 1);
        check("to_err", err_cnt, 3);
        send(8'h40); send(8'h41);
        check("to_frame", {fif.frame_addr, fif.frame_cmd}, 16'h4041);
        idle(2);

        // disable mid-frame, then re-enable
        send(8'h99);
        enable = 1'b0;
        tick();
        check("dis_en", rx_en, 0);
        enable = 1'b1;
        tick();
        send(8'hAA); send(8'hBB);
        check("dis_frame", {fif.frame_addr, fif.frame_cmd}, 16'hAABB);
        idle(2);

        // reset mid-frame
        send(8'h12);
        do_reset();
        idle(3);

        // saturation
        repeat (260) begin
            send(8'($urandom));
            idle(T + 1);
        end
        check("sat_err", err_cnt, 255);
        do_reset();

        // randomized traffic
        for (int seg = 0; seg < 20; seg++) begin
            int p;
            p = int'($urandom_range(1, 6));
            for (int c = 0; c < 200; c++) begin
                enable = ($urandom % 80) != 0;
                rx_err = ($urandom % 60) == 0;
                rx_done = ($urandom % p) == 0;
                rx_data = 8'($urandom);
                rx_busy = 1'($urandom);
                fif.frame_ready = ($urandom % 3) != 0;
                tick();
            end
        end
        rx_done = 1'b0;
        rx_err = 1'b0;
        fif.frame_ready = 1'b1;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
